sa_is_sequencer: RTL and testbench



---
 rtl/sa_pkg.sv | 14 +
 rtl/sa_is_sequencer_if.sv | 35 +++
 rtl/sa_valid_delay.sv | 18 +
 rtl/sa_is_sequencer.sv | 78 +++++++
 tb/tb_sa_is_sequencer.sv | 108 ++++++++++
 5 files changed

// File: rtl/sa_pkg.sv
// sa_pkg: shared defaults and FSM state codes for the systolic-array sequencer
package sa_pkg;
    localparam int DEF_ARRAY_HEIGHT = 4;
    localparam int DEF_ARRAY_WIDTH  = 4;
    localparam int DEF_MAX_W_ROWS   = 256;
    localparam int DEF_W_ADDR_WIDTH = 8;
    localparam int OUT_LAT_DEFAULT  = DEF_ARRAY_HEIGHT + DEF_ARRAY_WIDTH;
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_STREAM = 3'd2;
    localparam state_t ST_DRAIN  = 3'd3;
    localparam state_t ST_DONE   = 3'd4;
endpackage

// File: rtl/sa_is_sequencer_if.sv
// sa_is_sequencer_if: job, buffer-read and array-control signals of the sequencer
//   master: sequencer side (takes start/cfg/abort, drives status, reads, enables, tags)
//   slave : job issuer / buffers / array side
interface sa_is_sequencer_if
    import sa_pkg::*;
#(
    parameter int ARRAY_HEIGHT = DEF_ARRAY_HEIGHT,
    parameter int MAX_W_ROWS   = DEF_MAX_W_ROWS,
    parameter int W_ADDR_WIDTH = DEF_W_ADDR_WIDTH
);
    logic                              start;
    logic [$clog2(MAX_W_ROWS+1)-1:0]   cfg_num_w_rows;
    logic [W_ADDR_WIDTH-1:0]           cfg_w_base;
    logic                              abort;
    logic                              busy;
    logic                              done;
    logic                              in_rd_en;
    logic [$clog2(ARRAY_HEIGHT)-1:0]   in_rd_addr;
    logic                              w_rd_en;
    logic [W_ADDR_WIDTH-1:0]           w_rd_addr;
    logic                              input_en;
    logic                              process_en;
    logic                              out_valid;
    logic [$clog2(MAX_W_ROWS)-1:0]     out_idx;
    modport master (
        input  start, cfg_num_w_rows, cfg_w_base, abort,
        output busy, done, in_rd_en, in_rd_addr, w_rd_en, w_rd_addr,
               input_en, process_en, out_valid, out_idx
    );
    modport slave (
        output start, cfg_num_w_rows, cfg_w_base, abort,
        input  busy, done, in_rd_en, in_rd_addr, w_rd_en, w_rd_addr,
               input_en, process_en, out_valid, out_idx
    );
endinterface

// File: rtl/sa_valid_delay.sv
// sa_valid_delay: DEPTH-stage shift register with synchronous clear
//   clk, rst: clock, sync active-high reset
//   clr     : drop everything in flight
//   d, q    : bit in, bit out DEPTH cycles later
module sa_valid_delay #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic d,
    output logic q
);
    logic [DEPTH-1:0] sr;
    always_ff @(posedge clk)
        sr <= (rst || clr) ? '0 : DEPTH'({sr, d});
    assign q = sr[DEPTH-1];
endmodule

// File: rtl/sa_is_sequencer.sv
// sa_is_sequencer: per-job sequencing of input load, weight streaming and psum tagging
//   clk, rst : clock, sync active-high reset
//   bus      : start/cfg/abort in; busy/done, buffer read strobes/addresses,
//              array input_en/process_en, out_valid/out_idx out
module sa_is_sequencer
    import sa_pkg::*;
#(
    parameter int ARRAY_HEIGHT = DEF_ARRAY_HEIGHT,
    parameter int ARRAY_WIDTH  = DEF_ARRAY_WIDTH,
    parameter int MAX_W_ROWS   = DEF_MAX_W_ROWS,
    parameter int W_ADDR_WIDTH = DEF_W_ADDR_WIDTH,
    parameter int OUT_LAT      = ARRAY_HEIGHT + ARRAY_WIDTH
) (
    input  logic clk,
    input  logic rst,
    sa_is_sequencer_if.master bus
);
    localparam int NW = $clog2(MAX_W_ROWS + 1);
    localparam int HW = $clog2(ARRAY_HEIGHT);
    localparam int IW = $clog2(MAX_W_ROWS);
    state_t state, nxt;
    logic [NW-1:0] n, cnt;
    logic [W_ADDR_WIDTH-1:0] base;
    logic [IW-1:0] idx;
    logic in_en_q, proc_en_q, ov, last_out;
    always_comb begin
        last_out = ov && (NW'(idx) == n - NW'(1));
        nxt = ST_IDLE;
        case (state)
            ST_IDLE:   nxt = bus.start ? ST_LOAD : ST_IDLE;
            ST_LOAD:   nxt = (cnt == NW'(ARRAY_HEIGHT - 1)) ? ((n != '0) ? ST_STREAM : ST_DONE) : ST_LOAD;
            ST_STREAM: nxt = (cnt == n - NW'(1)) ? ST_DRAIN : ST_STREAM;
            ST_DRAIN:  nxt = last_out ? ST_DONE : ST_DRAIN;
            default:   nxt = ST_IDLE;
        endcase
        if (bus.abort)
            nxt = ST_IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            n         <= '0;
            base      <= '0;
            cnt       <= '0;
            idx       <= '0;
            in_en_q   <= 1'b0;
            proc_en_q <= 1'b0;
        end else begin
            state     <= nxt;
            // cnt restarts on every state change, so it is the row index within LOAD/STREAM
            cnt       <= (nxt != state || state == ST_IDLE) ? '0 : cnt + NW'(1);
            in_en_q   <= bus.in_rd_en && !bus.abort;
            proc_en_q <= bus.w_rd_en && !bus.abort;
            idx       <= (bus.abort || state == ST_IDLE || last_out) ? '0 : ov ? idx + IW'(1) : idx;
            if (state == ST_IDLE && bus.start) begin
                n    <= (bus.cfg_num_w_rows > NW'(MAX_W_ROWS)) ? NW'(MAX_W_ROWS) : bus.cfg_num_w_rows;
                base <= bus.cfg_w_base;
            end
        end
    end
    sa_valid_delay #(.DEPTH(OUT_LAT)) u_delay (
        .clk(clk),
        .rst(rst),
        .clr(bus.abort),
        .d(proc_en_q),
        .q(ov)
    );
    assign bus.busy       = state != ST_IDLE;
    assign bus.done       = state == ST_DONE;
    assign bus.in_rd_en   = state == ST_LOAD;
    assign bus.in_rd_addr = bus.in_rd_en ? HW'(cnt) : '0;
    assign bus.w_rd_en    = state == ST_STREAM;
    assign bus.w_rd_addr  = bus.w_rd_en ? base + W_ADDR_WIDTH'(cnt) : '0;
    assign bus.input_en   = in_en_q;
    assign bus.process_en = proc_en_q;
    assign bus.out_valid  = ov;
    assign bus.out_idx    = idx;
endmodule

// File: tb/tb_sa_is_sequencer.sv
// tb_sa_is_sequencer: cycle-accurate check of sa_is_sequencer against a timing model of each job
module tb_sa_is_sequencer;
    import sa_pkg::*;
    localparam int H = DEF_ARRAY_HEIGHT;
    localparam int L = OUT_LAT_DEFAULT;
    localparam int M = DEF_MAX_W_ROWS;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    always #5 clk = ~clk;
    sa_is_sequencer_if bus ();
    sa_is_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input int t, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int t);
        chk({tag, "_busy"}, t, int'(bus.busy), 0);
        chk({tag, "_done"}, t, int'(bus.done), 0);
        chk({tag, "_in_rd_en"}, t, int'(bus.in_rd_en), 0);
        chk({tag, "_in_rd_addr"}, t, int'(bus.in_rd_addr), 0);
        chk({tag, "_w_rd_en"}, t, int'(bus.w_rd_en), 0);
        chk({tag, "_w_rd_addr"}, t, int'(bus.w_rd_addr), 0);
        chk({tag, "_input_en"}, t, int'(bus.input_en), 0);
        chk({tag, "_process_en"}, t, int'(bus.process_en), 0);
        chk({tag, "_out_valid"}, t, int'(bus.out_valid), 0);
        chk({tag, "_out_idx"}, t, int'(bus.out_idx), 0);
    endtask

    // One job started at relative cycle 0; expected outputs come from the job's cycle timeline.
    task automatic run_job(input int ncfg, input int b, input int abort_at, input int rst_at, input int stray_at);
        int n, d, cut, lim;
        bit live, in_r, w_r, ov;
        n = ncfg > M ? M : ncfg;
        d = n == 0 ? H + 1 : H + n + 2 + L;
        cut = rst_at >= 0 ? rst_at : abort_at;
        lim = cut >= 0 ? cut + 1 : d + 1;
        for (int t = 0; t <= lim; t++) begin
            live = !(cut >= 0 && t > cut);
            in_r = live && t >= 1 && t <= H;
            w_r  = live && t >= H + 1 && t <= H + n;
            ov   = live && t >= H + 2 + L && t <= H + n + 1 + L;
            bus.start          = (t == 0 || t == stray_at);
            bus.cfg_num_w_rows = t == 0 ? 9'(ncfg) : 9'($urandom);
            bus.cfg_w_base     = t == 0 ? 8'(b) : 8'($urandom);
            bus.abort          = (t == abort_at);
            rst                = (t == rst_at);
            @(negedge clk);
            if (!live) chk_idle("cut", t);
            else begin
                chk("busy", t, int'(bus.busy), int'(t >= 1 && t <= d));
                chk("done", t, int'(bus.done), int'(t == d));
                chk("in_rd_en", t, int'(bus.in_rd_en), int'(in_r));
                if (in_r) chk("in_rd_addr", t, int'(bus.in_rd_addr), t - 1);
                chk("w_rd_en", t, int'(bus.w_rd_en), int'(w_r));
                if (w_r) chk("w_rd_addr", t, int'(bus.w_rd_addr), (b + t - H - 1) % 256);
                chk("input_en", t, int'(bus.input_en), int'(t >= 2 && t <= H + 1));
                chk("process_en", t, int'(bus.process_en), int'(t >= H + 2 && t <= H + n + 1));
                chk("out_valid", t, int'(bus.out_valid), int'(ov));
                if (ov) chk("out_idx", t, int'(bus.out_idx), t - H - 2 - L);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    initial begin
        int nr, br, d, ab;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.cfg_num_w_rows = '0;
        bus.cfg_w_base = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle("rst", -1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_job(4, 0, -1, -1, -1);
        run_job(0, 0, -1, -1, -1);
        run_job(4, 254, -1, -1, -1);
        run_job(4, 0, 10, -1, -1);
        run_job(4, 0, -1, -1, -1);
        run_job(4, 0, -1, -1, 7);
        run_job(4, 0, -1, 6, -1);
        run_job(300, 17, -1, -1, -1);
        run_job(256, 200, -1, -1, -1);
        for (int k = 0; k < 10; k++) begin
            nr = $urandom_range(0, 24);
            br = $urandom_range(0, 255);
            d  = nr == 0 ? H + 1 : H + nr + 2 + L;
            ab = $urandom_range(0, 2) == 0 ? $urandom_range(1, d) : -1;
            run_job(nr, br, ab, -1, $urandom_range(1, d));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
